perf_monitor: RTL and testbench
===============================

// Module: perf_monitor
// PURPOSE
//   In-core performance and completion monitor. Produces cycle, retire, fetch-advance and fetch-starve counts.
//   Detects program completion in hardware (PC out of range, or PC stalled with IFQ empty).
//   Software and benches read the counters through a small register read port.
//   Sits beside the fetch unit in top; taps imem_addr, ifq_empty, ifq_rd_en and the ROB commit pulse.
// PARAMETERS
//   XLEN           32       PC / read-data width
//   CNT_W          32       counter width (<= XLEN), saturating
//   STABLE_THRESH  6        consecutive stable-PC AND IFQ-empty cycles needed to declare halt
//   PC_LIMIT       32'h200  first PC outside program space; fetch at/above it = halt
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset
//   imem_addr    in   XLEN   current fetch PC
//   ifq_empty    in   1      instruction fetch queue empty
//   ifq_rd_en    in   1      IFQ pop (instruction dispatched)
//   commit_valid in   1      one instruction retired this cycle
//   soft_clr     in   1      clear counters, restart monitoring
//   rd_en        in   1      register read request
//   rd_addr      in   3      register index (map below)
//   rd_data      out  XLEN   read data, valid with rd_valid
//   rd_valid     out  1      read response, 1 cycle after rd_en
//   done         out  1      sticky program-complete flag
//   done_reason  out  2      0 none, 1 PC_LIMIT reached, 2 stall/drain detected
// BEHAVIOUR
//   - Reset: all counters 0, prev_pc 0, stable_cnt/empty_cnt 0, state IDLE; done=0, done_reason=0, rd_data=0, rd_valid=0.
//   - FSM: IDLE -> RUN on first cycle with rst=0.
//     - RUN -> DONE on halt detect. DONE holds until rst or soft_clr.
//     - soft_clr in any state: zero counters and stable/empty counts; go to RUN next cycle; done/done_reason cleared.
//     - rst has priority over soft_clr.
//   - In RUN, every cycle, including the cycle halt is detected:
//     - cyc_cnt += 1.
//     - ret_cnt += commit_valid.
//     - disp_cnt += ifq_rd_en.
//     - starve_cnt += ifq_empty.
//     - fetch_adv_cnt += (imem_addr != prev_pc).
//   - prev_pc <= imem_addr every RUN cycle.
//     - First RUN cycle: prev_pc is invalid; no advance is counted and stable_cnt is not incremented.
//   - stable_cnt: +1 when imem_addr == prev_pc, else 0; saturates at STABLE_THRESH.
//   - empty_cnt: +1 when ifq_empty, else 0; saturates at STABLE_THRESH.
//   - Halt detect, evaluated on the current-cycle registered counts:
//     - imem_addr >= PC_LIMIT (unsigned) -> reason 1.
//     - else stable_cnt == STABLE_THRESH && empty_cnt == STABLE_THRESH && ret_cnt != 0 -> reason 2.
//     - Both true in the same cycle -> reason 1 wins.
//   - done and done_reason register on the RUN->DONE edge: done=1 the cycle after detection.
//   - In DONE all counters freeze. Inputs are ignored except rd_*, soft_clr, rst.
//   - All counters saturate at {CNT_W{1}}; they never wrap.
//   - Read port: rd_en sampled at posedge N.
//     - rd_data/rd_valid are valid after posedge N+1.
//     - Returned value = register contents before the edge-N update (pre-increment snapshot).
//     - rd_valid=0 and rd_data holds its last value when there is no request. Back-to-back reads are allowed.
//   - Read map, zero-extended to XLEN:
//     - 0 cyc_cnt
//     - 1 ret_cnt
//     - 2 fetch_adv_cnt
//     - 3 starve_cnt
//     - 4 disp_cnt
//     - 5 prev_pc
//     - 6 status {.., done, done_reason[1:0], state[1:0]}
//     - 7 reads 0
//   - rst or soft_clr coincident with rd_en: the response still issues next cycle and returns post-clear zeros.
// STRUCTURE
//   - perf_pkg:
//     - perf_state_e (IDLE, RUN, DONE)
//     - done_reason_e (NONE, PC_LIMIT, DRAIN)
//     - register index localparams PERF_CYC..PERF_STATUS
//   - Sub-module sat_counter #(W): inc, clr, en, saturating count; instantiated five times.
//   - Top of file: FSM, stable/empty trackers, halt compare, read mux register.
// TESTING
//   1. Reset then 10 cycles, commit_valid each cycle, PC +4 each cycle -> read 0 = 10, read 1 = 10, read 2 = 9; done=0.
//   2. PC stuck at 0x20, ifq_empty=1, ret_cnt=3 -> done=1 with reason 2 exactly 7 cycles after the PC stops (6 to saturate, +1 register); counters frozen afterwards.
//   3. Same drain with ret_cnt=0 -> done stays 0 indefinitely.
//   4. imem_addr jumps to 0x200 while PC is also stable and IFQ empty -> done_reason=1 (priority check).
//   5. Preload counter to all-ones via forced input, pulse commit -> read 1 stays 0xFFFFFFFF (saturation).
//   6. soft_clr asserted in DONE with rd_en addr 0 in the same cycle -> rd_valid next cycle with data 0; done=0, FSM RUN.
//   7. rst pulse mid-RUN -> all outputs zero next cycle, FSM IDLE, then RUN.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared state/reason encodings and read-map indices for perf_monitor
package perf_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} perf_state_e;
    typedef enum logic [1:0] {REASON_NONE = 2'd0, REASON_PC_LIMIT = 2'd1, REASON_DRAIN = 2'd2} done_reason_e;
    localparam logic [2:0] PERF_CYC    = 3'd0;
    localparam logic [2:0] PERF_RET    = 3'd1;
    localparam logic [2:0] PERF_ADV    = 3'd2;
    localparam logic [2:0] PERF_STARVE = 3'd3;
    localparam logic [2:0] PERF_DISP   = 3'd4;
    localparam logic [2:0] PERF_PC     = 3'd5;
    localparam logic [2:0] PERF_STATUS = 3'd6;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable-gated counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (en_i && inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= (rst || clr_i) ? '0 : cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: cycle/retire/fetch counters, hardware halt detection and a registered read port
module perf_monitor
    import perf_pkg::*;
#(
    parameter int               XLEN          = 32,
    parameter int               CNT_W         = 32,
    parameter int               STABLE_THRESH = 6,
    parameter logic [XLEN-1:0]  PC_LIMIT      = 32'h200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] imem_addr,
    input  logic            ifq_empty,
    input  logic            ifq_rd_en,
    input  logic            commit_valid,
    input  logic            soft_clr,
    input  logic            rd_en,
    input  logic [2:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_valid,
    output logic            done,
    output logic [1:0]      done_reason
);
    localparam int SW = $clog2(STABLE_THRESH + 1);
    localparam logic [SW-1:0] THR = SW'(STABLE_THRESH);
    perf_state_e     state_q;
    done_reason_e    reason_q;
    logic [XLEN-1:0] prev_pc_q, rd_data_q, rd_mux;
    logic [SW-1:0]   stable_q, stable_d, empty_q, empty_d;
    logic            pc_valid_q, done_q, rd_valid_q;
    logic            same, adv, halt_lim, halt_drain, run;
    logic [4:0]      inc;
    logic [CNT_W-1:0] cnt [5];
    assign run  = state_q == RUN;
    assign same = pc_valid_q && imem_addr == prev_pc_q;
    assign adv  = pc_valid_q && imem_addr != prev_pc_q;
    assign inc  = {ifq_rd_en, ifq_empty, adv, commit_valid, 1'b1};
    for (genvar i = 0; i < 5; i++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (soft_clr),
            .en_i  (run),
            .inc_i (inc[i]),
            .cnt_o (cnt[i])
        );
    end
    // Halt looks at the counts registered before this cycle, so drain needs THR full cycles of history.
    assign halt_lim   = imem_addr >= PC_LIMIT;
    assign halt_drain = stable_q == THR && empty_q == THR && cnt[1] != '0;
    always_comb begin
        stable_d = same ? (stable_q == THR ? THR : stable_q + SW'(1)) : '0;
        empty_d  = ifq_empty ? (empty_q == THR ? THR : empty_q + SW'(1)) : '0;
    end
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            PERF_CYC:    rd_mux = XLEN'(cnt[0]);
            PERF_RET:    rd_mux = XLEN'(cnt[1]);
            PERF_ADV:    rd_mux = XLEN'(cnt[2]);
            PERF_STARVE: rd_mux = XLEN'(cnt[3]);
            PERF_DISP:   rd_mux = XLEN'(cnt[4]);
            PERF_PC:     rd_mux = prev_pc_q;
            PERF_STATUS: rd_mux = {{(XLEN-5){1'b0}}, done_q, reason_q, state_q};
            default:     rd_mux = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        rd_valid_q <= rd_en;
        if (rst || (rd_en && soft_clr)) rd_data_q <= '0;
        else if (rd_en) rd_data_q <= rd_mux;
        if (rst) begin
            state_q    <= IDLE;
            prev_pc_q  <= '0;
            pc_valid_q <= 1'b0;
            stable_q   <= '0;
            empty_q    <= '0;
            done_q     <= 1'b0;
            reason_q   <= REASON_NONE;
        end else if (soft_clr) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b0;
            stable_q   <= '0;
            empty_q    <= '0;
            done_q     <= 1'b0;
            reason_q   <= REASON_NONE;
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    prev_pc_q  <= imem_addr;
                    pc_valid_q <= 1'b1;
                    stable_q   <= stable_d;
                    empty_q    <= empty_d;
                    if (halt_lim || halt_drain) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        reason_q <= halt_lim ? REASON_PC_LIMIT : REASON_DRAIN;
                    end
                end
                default: ;
            endcase
        end
    end
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign done_reason = reason_q;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed stimulus, per-cycle model compare and literal checks for perf_monitor
module tb_perf_monitor;
    logic        clk = 0, rst = 1, ifq_empty = 0, ifq_rd_en = 0, commit_valid = 0, soft_clr = 0, rd_en = 0;
    logic [31:0] imem_addr = 0;
    logic [2:0]  rd_addr = 0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, done_a, done_b;
    logic [1:0]  reason_a, reason_b;
    int          total = 0, bad = 0;
    bit          chk_en = 0;

    always #5 clk = ~clk;

    perf_monitor u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .ifq_empty(ifq_empty), .ifq_rd_en(ifq_rd_en),
        .commit_valid(commit_valid), .soft_clr(soft_clr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .done(done_a), .done_reason(reason_a)
    );
    perf_monitor #(.CNT_W(4)) u_sml (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .ifq_empty(ifq_empty), .ifq_rd_en(ifq_rd_en),
        .commit_valid(commit_valid), .soft_clr(soft_clr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .done(done_b), .done_reason(reason_b)
    );

    // Model: true event counts, clamped to counter width only when observed.
    logic [1:0]  m_state = 0, m_reason = 0;
    longint      m_cnt[5] = '{0, 0, 0, 0, 0};
    logic [31:0] m_prev = 0, m_rd_a = 0, m_rd_b = 0;
    bit          m_pcv = 0, m_done = 0, m_rv = 0;
    int          m_same = 0, m_empty = 0;

    function automatic logic [31:0] clampv(input longint v, input int w);
        longint mx = (64'd1 << w) - 1;
        return 32'(v > mx ? mx : v);
    endfunction

    function automatic logic [31:0] rd_val(input logic [2:0] a, input int w);
        if (a < 3'd5) return clampv(m_cnt[a], w);
        if (a == 3'd5) return m_prev;
        if (a == 3'd6) return {27'b0, m_done, m_reason, m_state};
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        bit h1, h2, sm;
        m_rv = rd_en;
        if (rst) begin
            m_rd_a = 0; m_rd_b = 0; m_state = 0; m_prev = 0; m_pcv = 0;
            m_same = 0; m_empty = 0; m_done = 0; m_reason = 0;
            for (int k = 0; k < 5; k++) m_cnt[k] = 0;
        end else begin
            if (rd_en) begin
                m_rd_a = soft_clr ? 32'd0 : rd_val(rd_addr, 32);
                m_rd_b = soft_clr ? 32'd0 : rd_val(rd_addr, 4);
            end
            if (soft_clr) begin
                m_state = 1; m_pcv = 0; m_same = 0; m_empty = 0; m_done = 0; m_reason = 0;
                for (int k = 0; k < 5; k++) m_cnt[k] = 0;
            end else if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                h1 = imem_addr >= 32'h200;
                h2 = m_same >= 6 && m_empty >= 6 && m_cnt[1] != 0;
                sm = m_pcv && imem_addr == m_prev;
                m_cnt[0] += 1;
                m_cnt[1] += longint'(commit_valid);
                m_cnt[2] += longint'(m_pcv && !sm);
                m_cnt[3] += longint'(ifq_empty);
                m_cnt[4] += longint'(ifq_rd_en);
                m_same  = sm ? (m_same < 6 ? m_same + 1 : 6) : 0;
                m_empty = ifq_empty ? (m_empty < 6 ? m_empty + 1 : 6) : 0;
                m_prev = imem_addr;
                m_pcv = 1;
                if (h1 || h2) begin m_state = 2; m_done = 1; m_reason = h1 ? 2'd1 : 2'd2; end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("done_a", 32'(done_a), 32'(m_done));
        chk("reason_a", 32'(reason_a), 32'(m_reason));
        chk("rd_valid_a", 32'(rd_valid_a), 32'(m_rv));
        chk("rd_data_a", rd_data_a, m_rd_a);
        chk("done_b", 32'(done_b), 32'(m_done));
        chk("reason_b", 32'(reason_b), 32'(m_reason));
        chk("rd_valid_b", 32'(rd_valid_b), 32'(m_rv));
        chk("rd_data_b", rd_data_b, m_rd_b);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1; rd_addr = a; tick(1); rd_en = 0;
    endtask

    initial begin
        tick(2);
        chk_en = 1;
        chk("rst_done", 32'(done_a), 0);
        chk("rst_valid", 32'(rd_valid_a), 0);
        chk("rst_data", rd_data_a, 0);
        // 1: ten committing cycles with PC stepping by 4
        rst = 0; tick(1);
        for (int k = 0; k < 10; k++) begin
            imem_addr = 32'(4 * k); commit_valid = 1; ifq_rd_en = k[0]; tick(1);
        end
        commit_valid = 0; ifq_rd_en = 0;
        rd(3'd0); chk("t1_cyc", rd_data_a, 10); chk("t1_valid", 32'(rd_valid_a), 1);
        rd(3'd1); chk("t1_ret", rd_data_a, 10);
        rd(3'd2); chk("t1_adv", rd_data_a, 9);
        rd(3'd4); chk("t1_disp", rd_data_a, 5);
        rd(3'd5); chk("t1_pc", rd_data_a, 32'h24);
        chk("t1_done", 32'(done_a), 0);
        // 2: drain halt with three retirements
        soft_clr = 1; tick(1); soft_clr = 0;
        for (int k = 0; k < 3; k++) begin imem_addr = 32'h10 + 32'(4 * k); commit_valid = 1; tick(1); end
        imem_addr = 32'h20; commit_valid = 0; ifq_empty = 1; tick(1);
        for (int k = 1; k <= 6; k++) begin tick(1); chk("t2_not_yet", 32'(done_a), 0); end
        tick(1);
        chk("t2_done", 32'(done_a), 1); chk("t2_reason", 32'(reason_a), 2);
        rd(3'd0); chk("t2_cyc", rd_data_a, 11);
        rd(3'd1); chk("t2_ret", rd_data_a, 3);
        rd(3'd2); chk("t2_adv", rd_data_a, 3);
        rd(3'd3); chk("t2_starve", rd_data_a, 8);
        rd(3'd6); chk("t2_status", rd_data_a, 26);
        rd(3'd0); chk("t2_frozen", rd_data_a, 11);
        rd(3'd7); chk("t2_addr7", rd_data_a, 0);
        // 3: drain without retirement never halts
        soft_clr = 1; tick(1); soft_clr = 0;
        imem_addr = 32'h40; tick(20);
        chk("t3_done", 32'(done_a), 0);
        rd(3'd0); chk("t3_cyc", rd_data_a, 20);
        rd(3'd2); chk("t3_adv", rd_data_a, 0);
        rd(3'd3); chk("t3_starve", rd_data_a, 22);
        // 4: PC limit and drain in the same cycle, limit wins
        soft_clr = 1; tick(1); soft_clr = 0;
        imem_addr = 32'h80; commit_valid = 1; tick(1); commit_valid = 0;
        tick(6); chk("t4_not_yet", 32'(done_a), 0);
        imem_addr = 32'h200; tick(1);
        chk("t4_done", 32'(done_a), 1); chk("t4_reason", 32'(reason_a), 1);
        // 6: soft clear from DONE with a coincident read
        imem_addr = 0; ifq_empty = 0;
        soft_clr = 1; rd(3'd0); soft_clr = 0;
        chk("t6_valid", 32'(rd_valid_a), 1); chk("t6_data", rd_data_a, 0); chk("t6_done", 32'(done_a), 0);
        rd(3'd6); chk("t6_status", rd_data_a, 1);
        tick(1); chk("t6_idle_valid", 32'(rd_valid_a), 0);
        // 5: saturation on the narrow instance
        soft_clr = 1; tick(1); soft_clr = 0;
        for (int k = 0; k < 20; k++) begin imem_addr = 32'h100 + 32'(4 * k); commit_valid = 1; tick(1); end
        commit_valid = 0;
        rd(3'd1); chk("t5_ret_a", rd_data_a, 20); chk("t5_ret_b", rd_data_b, 15);
        rd(3'd0); chk("t5_cyc_b", rd_data_b, 15);
        commit_valid = 1; tick(3); commit_valid = 0;
        rd(3'd1); chk("t5_ret_sat", rd_data_b, 15); chk("t5_ret_a2", rd_data_a, 23);
        // 7: reset mid-run
        rst = 1; tick(1);
        chk("t7_done", 32'(done_a), 0); chk("t7_reason", 32'(reason_a), 0);
        chk("t7_valid", 32'(rd_valid_a), 0); chk("t7_data", rd_data_a, 0);
        rst = 0;
        rd(3'd6); chk("t7_idle", rd_data_a, 0);
        rd(3'd6); chk("t7_run", rd_data_a, 1);
        tick(3);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
